// File: rtl/dma_peripheral_responder_pkg.sv
// Shared types and constants for the DMA peripheral responder.
package dma_pkg;

  localparam int unsigned NUM_CH = 4;

  localparam bit DIR_DEV2MEM = 1'b0;
  localparam bit DIR_MEM2DEV = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    ACK,
    XFER,
    DONE
  } dma_resp_state_e;

endpackage

// File: rtl/dma_peripheral_responder_if.sv
// DMA channel bus handshake as seen between the controller and one peripheral.
interface dma_peripheral_responder_if
  import dma_pkg::*;
#(
  parameter int unsigned DATA_W = 8
);

  logic [NUM_CH-1:0] DREQ;
  logic [NUM_CH-1:0] DACK;
  logic              IOR_N;
  logic              IOW_N;
  logic              EOP_N;
  logic [DATA_W-1:0] DB_IN;
  logic [DATA_W-1:0] DB_OUT;
  logic              DB_OE;

  modport slave (
    output DREQ, DB_OUT, DB_OE,
    input  DACK, IOR_N, IOW_N, EOP_N, DB_IN
  );

  modport master (
    input  DREQ, DB_OUT, DB_OE,
    output DACK, IOR_N, IOW_N, EOP_N, DB_IN
  );

endinterface

// File: rtl/dma_peripheral_responder_fifo.sv
// Data FIFO between the DMA bus side and the local valid/ready port.
module dma_periph_fifo #(
  parameter  int unsigned DATA_W = 8,
  parameter  int unsigned DEPTH  = 8,
  localparam int unsigned AW     = $clog2(DEPTH),
  localparam int unsigned LW     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty,
  output logic [LW-1:0]     level
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end

endmodule

// File: rtl/dma_peripheral_responder.sv
// Peripheral end of a DMA channel: requests service, answers IOR_N/IOW_N strobes
// from its FIFO, and stops requesting on terminal count.
module dma_peripheral_responder
  import dma_pkg::*;
#(
  parameter  int unsigned CHANNEL = 0,
  parameter  int unsigned DATA_W  = 8,
  parameter  int unsigned DEPTH   = 8,
  localparam int unsigned LW      = $clog2(DEPTH + 1)
) (
  input  logic                       CLK,
  input  logic                       RESET,
  dma_peripheral_responder_if.slave  bus,
  input  logic                       en,
  input  logic                       dir,
  input  logic                       demand,
  input  logic                       push_valid,
  input  logic [DATA_W-1:0]          push_data,
  output logic                       push_ready,
  output logic                       pop_valid,
  output logic [DATA_W-1:0]          pop_data,
  input  logic                       pop_ready,
  output logic [LW-1:0]              level,
  output logic                       tc_done,
  output logic                       proto_err
);

  localparam logic [LW:0] DEPTH_L = (LW + 1)'(DEPTH);

  dma_resp_state_e   state;
  logic              dir_q, demand_q, strb_q, eop_seen, dreq_q;
  logic [DATA_W-1:0] db_in_q, head, fifo_wdata;
  logic              full, empty, db_oe;
  logic              ack, strb, opp_strb, strb_rise, commit;
  logic              bus_push, bus_pop, bus_overrun, local_push, local_pop;
  logic              fifo_push, fifo_pop;
  logic [LW:0]       lvl_after;
  logic              req_now, req_in, req_after, eop_now, err_now;

  assign push_ready = !full && (dir_q == DIR_DEV2MEM);
  assign pop_valid  = !empty && (dir_q == DIR_MEM2DEV);
  assign pop_data   = head;

  // A commit happens on the strobe's trailing edge; only one side of the FIFO
  // is bus-facing at a time, so bus and local traffic never collide.
  always_comb begin
    ack         = bus.DACK[CHANNEL];
    strb        = dir_q ? ~bus.IOW_N : ~bus.IOR_N;
    opp_strb    = dir_q ? ~bus.IOR_N : ~bus.IOW_N;
    strb_rise   = strb_q && !strb;
    commit      = (state == XFER) && ack && strb_rise;
    bus_pop     = commit && (dir_q == DIR_DEV2MEM) && !empty;
    bus_push    = commit && (dir_q == DIR_MEM2DEV) && !full;
    bus_overrun = commit && !(bus_pop || bus_push);
    local_push  = push_valid && push_ready;
    local_pop   = pop_valid && pop_ready;
    fifo_push   = bus_push || local_push;
    fifo_pop    = bus_pop || local_pop;
    fifo_wdata  = dir_q ? db_in_q : push_data;
    lvl_after   = {1'b0, level} + {{LW{1'b0}}, fifo_push} - {{LW{1'b0}}, fifo_pop};
    req_now     = dir_q ? !full : !empty;
    req_in      = dir ? !full : !empty;
    req_after   = dir_q ? (lvl_after != DEPTH_L) : (lvl_after != '0);
    eop_now     = eop_seen || !bus.EOP_N;
    err_now     = ((state == REQ || state == ACK || state == XFER) && ack && opp_strb)
               || ((state == ACK || state == XFER) && !ack && (strb || state == XFER))
               || bus_overrun;
    db_oe       = (state == ACK || state == XFER) && (dir_q == DIR_DEV2MEM) && ack && strb;
  end

  always_comb begin
    bus.DREQ          = '0;
    bus.DREQ[CHANNEL] = dreq_q;
    bus.DB_OE         = db_oe;
    bus.DB_OUT        = db_oe ? head : '0;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= IDLE;
      dir_q     <= DIR_DEV2MEM;
      demand_q  <= 1'b0;
      strb_q    <= 1'b0;
      eop_seen  <= 1'b0;
      dreq_q    <= 1'b0;
      db_in_q   <= '0;
      tc_done   <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      strb_q    <= strb;
      tc_done   <= 1'b0;
      proto_err <= err_now;
      if (strb) db_in_q <= bus.DB_IN;
      unique case (state)
        IDLE: begin
          dir_q    <= dir;
          demand_q <= demand;
          eop_seen <= 1'b0;
          if (en && req_in) begin
            state  <= REQ;
            dreq_q <= 1'b1;
          end
        end
        REQ: begin
          if (ack) begin
            state <= ACK;
          end else if (!en) begin
            state  <= IDLE;
            dreq_q <= 1'b0;
          end
        end
        ACK: begin
          if (!ack) begin
            eop_seen <= 1'b0;
            if (req_now) begin
              state <= REQ;
            end else begin
              state  <= IDLE;
              dreq_q <= 1'b0;
            end
          end else begin
            eop_seen <= eop_now;
            if (strb) state <= XFER;
          end
        end
        XFER: begin
          if (!ack) begin
            state    <= IDLE;
            dreq_q   <= 1'b0;
            eop_seen <= 1'b0;
          end else if (strb_rise) begin
            eop_seen <= 1'b0;
            if (eop_now) begin
              state   <= DONE;
              dreq_q  <= 1'b0;
              tc_done <= 1'b1;
            end else if (demand_q && req_after) begin
              state <= ACK;
            end else begin
              state  <= IDLE;
              dreq_q <= 1'b0;
            end
          end else begin
            eop_seen <= eop_now;
          end
        end
        DONE: begin
          if (!en) state <= IDLE;
        end
        default: begin
          state  <= IDLE;
          dreq_q <= 1'b0;
        end
      endcase
    end
  end

  dma_periph_fifo #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (CLK),
    .rst      (RESET),
    .push     (fifo_push),
    .push_data(fifo_wdata),
    .pop      (fifo_pop),
    .head     (head),
    .full     (full),
    .empty    (empty),
    .level    (level)
  );

endmodule

// File: tb/tb_dma_peripheral_responder.sv
// Self-checking bench for dma_peripheral_responder on channel 2.
`timescale 1ns/1ps
module tb_dma_peripheral_responder;
  import dma_pkg::*;

  localparam int unsigned CH = 2;
  localparam int unsigned DW = 8;
  localparam int unsigned DP = 8;
  localparam int unsigned LW = $clog2(DP + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          en, dir, demand;
  logic          push_valid, push_ready, pop_valid, pop_ready;
  logic [DW-1:0] push_data, pop_data;
  logic [LW-1:0] level;
  logic          tc_done, proto_err;

  int errors = 0;
  int checks = 0;

  dma_peripheral_responder_if #(.DATA_W(DW)) bus ();

  dma_peripheral_responder #(
    .CHANNEL(CH),
    .DATA_W (DW),
    .DEPTH  (DP)
  ) dut (
    .CLK       (clk),
    .RESET     (rst),
    .bus       (bus),
    .en        (en),
    .dir       (dir),
    .demand    (demand),
    .push_valid(push_valid),
    .push_data (push_data),
    .push_ready(push_ready),
    .pop_valid (pop_valid),
    .pop_data  (pop_data),
    .pop_ready (pop_ready),
    .level     (level),
    .tc_done   (tc_done),
    .proto_err (proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          dir;
    bit          en;
    int          nfill;
    logic [3:0]  dreq;
    logic [LW-1:0] lvl;
    bit          pr;
    bit          pv;
  } vec_t;

  vec_t       vecs[7];
  logic [7:0] model[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_bus();
    bus.DACK  = '0;
    bus.IOR_N = 1'b1;
    bus.IOW_N = 1'b1;
    bus.EOP_N = 1'b1;
    bus.DB_IN = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; dir = 1'b0; demand = 1'b0;
    push_valid = 1'b0; push_data = '0; pop_ready = 1'b0;
    idle_bus();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic local_push(input logic [7:0] d);
    push_valid = 1'b1;
    push_data  = d;
    step();
    push_valid = 1'b0;
  endtask

  task automatic wait_dreq(input string name, input int maxc);
    for (int i = 0; i < maxc && bus.DREQ !== 4'b0100; i++) step();
    chk(name, bus.DREQ, 4'b0100);
  endtask

  task automatic grant();
    bus.DACK = 4'b0100;
    step();
  endtask

  // One bus strobe of 'hold' cycles; on reads the driven data is checked every cycle.
  task automatic strobe(input bit wr, input logic [7:0] wdata, input int hold, input bit eop,
                        input bit chk_rd, input logic [7:0] exp_rd);
    bus.DB_IN = wdata;
    if (wr) bus.IOW_N = 1'b0;
    else    bus.IOR_N = 1'b0;
    bus.EOP_N = !eop;
    for (int c = 0; c < hold; c++) begin
      #1;
      if (chk_rd) begin
        chk("db_oe", bus.DB_OE, 1);
        chk("db_out", bus.DB_OUT, exp_rd);
      end
      step();
    end
    bus.IOW_N = 1'b1;
    bus.IOR_N = 1'b1;
    bus.EOP_N = 1'b1;
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit         d, dm, exp_more, ack_held;
    int         k, hold;
    logic [7:0] data;

    // reset state
    do_reset();
    #1;
    chk("rst_dreq", bus.DREQ, 0);
    chk("rst_db_oe", bus.DB_OE, 0);
    chk("rst_db_out", bus.DB_OUT, 0);
    chk("rst_level", level, 0);
    chk("rst_tc_done", tc_done, 0);
    chk("rst_proto_err", proto_err, 0);
    chk("rst_pop_valid", pop_valid, 0);
    chk("rst_state", int'(dut.state), int'(IDLE));

    // request gating table: {dir, en, prefill} -> {DREQ, level, push_ready, pop_valid}
    vecs[0] = '{1'b0, 1'b1, 0, 4'b0000, LW'(0), 1'b1, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 1, 4'b0100, LW'(1), 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 3, 4'b0000, LW'(3), 1'b1, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 0, 4'b0100, LW'(0), 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 0, 4'b0000, LW'(0), 1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 2, 4'b0100, LW'(2), 1'b0, 1'b1};
    vecs[6] = '{1'b0, 1'b1, 8, 4'b0100, LW'(8), 1'b0, 1'b0};
    for (int v = 0; v < 7; v++) begin
      do_reset();
      for (int n = 0; n < vecs[v].nfill; n++) local_push(8'(8'h60 + n));
      dir = vecs[v].dir;
      en  = vecs[v].en;
      step(); step(); step();
      chk("vec_dreq", bus.DREQ, vecs[v].dreq);
      chk("vec_level", level, vecs[v].lvl);
      chk("vec_push_ready", push_ready, vecs[v].pr);
      chk("vec_pop_valid", pop_valid, vecs[v].pv);
    end

    // single read transfer on channel 2
    do_reset();
    local_push(8'hA5);
    chk("t1_level_pre", level, 1);
    en = 1'b1;
    wait_dreq("t1_dreq", 2);
    grant();
    strobe(1'b0, 8'h00, 2, 1'b0, 1'b1, 8'hA5);
    chk("t1_level_post", level, 0);
    chk("t1_dreq_drop", bus.DREQ, 0);

    // demand write burst fills the FIFO
    do_reset();
    dir = 1'b1; demand = 1'b1; en = 1'b1;
    wait_dreq("t2_dreq", 3);
    grant();
    for (int i = 0; i < 8; i++) begin
      strobe(1'b1, 8'(8'h10 + i), 1, 1'b0, 1'b0, 8'h00);
      chk("t2_level", level, i + 1);
      chk("t2_dreq", bus.DREQ, (i < 7) ? 4'b0100 : 4'b0000);
    end
    idle_bus();
    en = 1'b0;
    pop_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("t2_pop_valid", pop_valid, 1);
      chk("t2_pop_data", pop_data, 8'h10 + i);
      step();
    end
    pop_ready = 1'b0;
    chk("t2_empty", pop_valid, 0);

    // terminal count on the second of three reads
    do_reset();
    demand = 1'b1;
    local_push(8'h31); local_push(8'h32); local_push(8'h33);
    en = 1'b1;
    wait_dreq("t3_dreq", 3);
    grant();
    strobe(1'b0, 8'h00, 1, 1'b0, 1'b1, 8'h31);
    chk("t3_dreq_mid", bus.DREQ, 4'b0100);
    chk("t3_level_mid", level, 2);
    strobe(1'b0, 8'h00, 1, 1'b1, 1'b1, 8'h32);
    chk("t3_tc_done", tc_done, 1);
    chk("t3_dreq_done", bus.DREQ, 0);
    chk("t3_level", level, 1);
    step();
    chk("t3_tc_pulse", tc_done, 0);
    idle_bus();
    step(); step(); step();
    chk("t3_dreq_held_off", bus.DREQ, 0);
    en = 1'b0; step();
    en = 1'b1; step();
    chk("t3_dreq_reen", bus.DREQ, 4'b0100);

    // DACK dropped mid-strobe
    do_reset();
    local_push(8'h4C);
    en = 1'b1;
    wait_dreq("t4_dreq", 3);
    grant();
    bus.IOR_N = 1'b0; step();
    bus.DACK = '0; step();
    chk("t4_proto_err", proto_err, 1);
    chk("t4_level", level, 1);
    chk("t4_dreq", bus.DREQ, 0);
    bus.IOR_N = 1'b1; step();
    chk("t4_err_pulse", proto_err, 0);
    chk("t4_rereq", bus.DREQ, 4'b0100);

    // opposite-direction strobe while acknowledged
    do_reset();
    local_push(8'h77);
    en = 1'b1;
    wait_dreq("t7_dreq", 3);
    grant();
    bus.IOW_N = 1'b0; step();
    chk("t7_proto_err", proto_err, 1);
    bus.IOW_N = 1'b1; step();
    chk("t7_err_clear", proto_err, 0);

    // reset during a read strobe
    do_reset();
    local_push(8'h5A);
    en = 1'b1;
    wait_dreq("t5_dreq", 3);
    grant();
    bus.IOR_N = 1'b0; step();
    chk("t5_in_xfer", int'(dut.state), int'(XFER));
    rst = 1'b1; step(); #1;
    chk("t5_dreq", bus.DREQ, 0);
    chk("t5_db_oe", bus.DB_OE, 0);
    chk("t5_level", level, 0);
    chk("t5_state", int'(dut.state), int'(IDLE));
    rst = 1'b0;

    // simultaneous local pop and bus write
    do_reset();
    dir = 1'b1; demand = 1'b1; en = 1'b1;
    wait_dreq("t6_dreq", 3);
    grant();
    for (int i = 0; i < 4; i++) strobe(1'b1, 8'(8'h40 + i), 1, 1'b0, 1'b0, 8'h00);
    chk("t6_level_pre", level, 4);
    bus.DB_IN = 8'h44; bus.IOW_N = 1'b0; step();
    bus.IOW_N = 1'b1; pop_ready = 1'b1; #1;
    chk("t6_pop_head", pop_data, 8'h40);
    step();
    pop_ready = 1'b0;
    chk("t6_level_same", level, 4);
    idle_bus(); en = 1'b0; step(); step();
    pop_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t6_order", pop_data, 8'h41 + i);
      step();
    end
    pop_ready = 1'b0;
    chk("t6_level_end", level, 0);

    // randomized episodes against a queue model
    for (int ep = 0; ep < 12; ep++) begin
      d  = 1'($urandom_range(0, 1));
      dm = 1'($urandom_range(0, 1));
      k  = int'($urandom_range(1, DP));
      do_reset();
      model.delete();
      dir = d; demand = dm;
      if (!d) begin
        for (int n = 0; n < k; n++) begin
          data = 8'($urandom);
          local_push(data);
          model.push_back(data);
        end
      end
      en = 1'b1;
      ack_held = 1'b0;
      for (int w = 0; w < k; w++) begin
        if (!ack_held) begin
          wait_dreq("rnd_dreq", 3);
          grant();
        end
        hold = int'($urandom_range(1, 3));
        if (d) begin
          data = 8'($urandom);
          strobe(1'b1, data, hold, 1'b0, 1'b0, 8'h00);
          model.push_back(data);
        end else begin
          strobe(1'b0, 8'h00, hold, 1'b0, 1'b1, model[0]);
          void'(model.pop_front());
        end
        chk("rnd_level", level, model.size());
        exp_more = dm && (d ? (model.size() < DP) : (model.size() > 0));
        chk("rnd_dreq_after", bus.DREQ, exp_more ? 4'b0100 : 4'b0000);
        if (!exp_more) bus.DACK = '0;
        ack_held = exp_more;
      end
      bus.DACK = '0; en = 1'b0;
      step(); step();
      if (d) begin
        for (int g = 0; g < 40 && model.size() > 0; g++) begin
          pop_ready = 1'($urandom_range(0, 1));
          if (pop_ready) begin
            chk("rnd_pop_valid", pop_valid, 1);
            chk("rnd_pop_data", pop_data, model.pop_front());
          end
          step();
        end
        pop_ready = 1'b0;
      end
      chk("rnd_final_level", level, model.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
